cnn_flow_monitor: RTL
=====================

Name: cnn_flow_monitor

Overview:
- Synthesizable, parametrised per-frame flow monitor for the CNN accelerator.
- Taps the input pixel strobe, the valid strobes of NUM_STAGES intermediate stages (conv1, maxpool1, conv2, fc, ...) and the final result strobe.
- Reports per-stage beat counts, first-pixel-to-result latency and the captured decision.
- Flags timeout, expected-count mismatch, surplus pixels and early results, so bring-up on silicon/FPGA needs no simulator.

Parameters:
NUM_STAGES, 4, number of monitored intermediate valid strobes
CNT_W, 16, width of each stage and pixel counter (saturating)
FRAME_PIXELS, 784, input beats per frame
LAT_W, 20, width of the latency/cycle counter
TIMEOUT_CYCLES, 100000, cycles from first pixel without result before timeout
DEC_W, 4, width of the decision result
EXP_COUNTS, 0, NUM_STAGES*CNT_W flattened expected beats per stage; a field of 0 means don't-care

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of state, counters and flags; highest priority after reset
pix_valid  in  1  input pixel accepted by the DUT this cycle
stage_valid  in  NUM_STAGES  per-stage output valid strobes, bit i = stage i
result_valid  in  1  final decision valid
result_data  in  DEC_W  final decision
busy  out  1  high in FEED or DRAIN
done  out  1  one-cycle pulse on frame completion or timeout
decision_q  out  DEC_W  captured decision
latency  out  LAT_W  cycles from first pixel to result
stage_cnt  out  NUM_STAGES*CNT_W  flattened per-stage beat counts of the last/current frame
count_err  out  NUM_STAGES  bit i set if stage i count differs from its nonzero expected count
err_flags  out  3  {timeout, extra_pix, early_result}, sticky until next frame start or clear

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs, counters and flags 0.
- FSM states: IDLE, FEED, DRAIN, HALT.
- IDLE:
  - pix_valid starts a frame: pix_cnt=1, cyc=0, stage counts, count_err and err_flags cleared, go to FEED.
  - result_valid and stage_valid are ignored.
  - Start has priority over a simultaneous result_valid.
  - If FRAME_PIXELS==1, go directly to DRAIN.
- FEED:
  - Each pix_valid increments pix_cnt.
  - When the increment makes pix_cnt==FRAME_PIXELS, go to DRAIN next cycle.
- DRAIN: pix_valid sets err_flags[1] (extra_pix); the frame continues.
- Counting (FEED and DRAIN):
  - cyc increments every cycle; first-pixel cycle is cyc=0.
  - Each stage_valid[i] increments stage i count, saturating at 2^CNT_W-1.
- Result (result_valid in FEED or DRAIN):
  - decision_q<=result_data; latency<=cyc (count at that cycle).
  - count_err[i] <= (EXP[i]!=0) && (cnt_i_including_this_cycle != EXP[i]).
  - done pulses the next cycle; state returns to IDLE.
  - If in FEED and this cycle's pixel does not complete the frame, set err_flags[0] (early_result).
  - Last pixel and result_valid in the same cycle is not early.
- Timeout: cyc reaching TIMEOUT_CYCLES-1 without a result sets err_flags[2], pulses done, enters HALT.
- HALT:
  - All inputs ignored; busy=0; outputs hold.
  - Leave only via clear or reset.
- Counter limits:
  - cyc saturates at 2^LAT_W-1.
  - Timeout fires before saturation when TIMEOUT_CYCLES<2^LAT_W (a requirement on parameters).
- clear: next edge gives state IDLE and zeroes counters, flags, decision_q, latency and done. Applies from any state, including mid-frame.
- Outputs: all registered; update on the edge after the causing input.
- Back-to-back: a new frame may start the cycle after done (IDLE accepts pix_valid immediately).

Test Plan:
- FRAME_PIXELS=16, EXP_COUNTS={stage0=9,stage1=4,others 0}: 16 contiguous pixels, 9/4 stage beats, result 4'd7 at cyc 40 -> done one pulse, decision_q=7, latency=40, count_err=0, err_flags=0.
- Same frame with stage0 giving 8 beats -> count_err=4'b0001; other outputs as nominal.
- TIMEOUT_CYCLES=100, no result -> err_flags=3'b100, done pulse at cyc 99 (+1 register), busy=0, pixels afterwards ignored; clear -> all zero, IDLE.
- 17 pixels then result -> err_flags[1]=1. Result after 10 pixels -> err_flags[0]=1, latency=9 (result on the 10th-pixel cycle is still early).
- clear asserted mid-FEED, then rst_n pulsed mid-DRAIN in a second frame -> both return to IDLE with all outputs 0; the next frame counts from zero correctly.
- Result in IDLE with simultaneous pix_valid -> frame starts, decision_q unchanged, no done.

Source files
------------

// File: rtl/cnn_flow_monitor.sv
// cnn_flow_monitor: per-frame flow monitor for the CNN accelerator.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous clear of state, counters and flags
//   pix_valid       input pixel accepted this cycle
//   stage_valid     per-stage output valid strobes (bit i = stage i)
//   result_valid    final decision valid, result_data = decision
//   busy            frame in progress (FEED or DRAIN)
//   done            one-cycle pulse on frame completion or timeout
//   decision_q      captured decision
//   latency         cycles from first pixel to result
//   stage_cnt       flattened per-stage beat counts
//   count_err       stage i count differs from its nonzero expected count
//   err_flags       {timeout, extra_pix, early_result}
module cnn_flow_monitor #(
   parameter int NUM_STAGES = 4,
   parameter int CNT_W = 16,
   parameter int FRAME_PIXELS = 784,
   parameter int LAT_W = 20,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int DEC_W = 4,
   parameter logic [NUM_STAGES*CNT_W-1:0] EXP_COUNTS = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        pix_valid,
   input  logic [NUM_STAGES-1:0]       stage_valid,
   input  logic                        result_valid,
   input  logic [DEC_W-1:0]            result_data,
   output logic                        busy,
   output logic                        done,
   output logic [DEC_W-1:0]            decision_q,
   output logic [LAT_W-1:0]            latency,
   output logic [NUM_STAGES*CNT_W-1:0] stage_cnt,
   output logic [NUM_STAGES-1:0]       count_err,
   output logic [2:0]                  err_flags
);
   typedef enum logic [1:0] {IDLE, FEED, DRAIN, HALT} state_t;
   localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(FRAME_PIXELS);
   localparam logic [LAT_W-1:0] TO_LAST = LAT_W'(TIMEOUT_CYCLES - 1);
   state_t state;
   logic [CNT_W-1:0] pix_cnt, pix_nxt;
   logic [LAT_W-1:0] cyc, cyc_nxt;
   logic [NUM_STAGES*CNT_W-1:0] cnt_nxt;
   logic [NUM_STAGES-1:0] err_nxt;
   logic last_pix;
   assign busy = state == FEED || state == DRAIN;
   assign pix_nxt = pix_cnt + CNT_W'(pix_valid && pix_cnt != '1);
   assign cyc_nxt = cyc + LAT_W'(cyc != '1);
   assign last_pix = state == FEED && pix_valid && pix_nxt == PIX_LAST;
   // stage counts including this cycle's beats, and their check against the expected totals
   always_comb begin
      cnt_nxt = stage_cnt;
      err_nxt = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         cnt_nxt[i*CNT_W +: CNT_W] = stage_cnt[i*CNT_W +: CNT_W]
            + CNT_W'(stage_valid[i] && stage_cnt[i*CNT_W +: CNT_W] != '1);
         err_nxt[i] = EXP_COUNTS[i*CNT_W +: CNT_W] != '0
            && cnt_nxt[i*CNT_W +: CNT_W] != EXP_COUNTS[i*CNT_W +: CNT_W];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pix_cnt <= '0;
         cyc <= '0;
         done <= 1'b0;
         decision_q <= '0;
         latency <= '0;
         stage_cnt <= '0;
         count_err <= '0;
         err_flags <= '0;
      end else if (clear) begin
         state <= IDLE;
         pix_cnt <= '0;
         cyc <= '0;
         done <= 1'b0;
         decision_q <= '0;
         latency <= '0;
         stage_cnt <= '0;
         count_err <= '0;
         err_flags <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (pix_valid) begin
               state <= FRAME_PIXELS == 1 ? DRAIN : FEED;
               pix_cnt <= CNT_W'(1);
               // the start cycle is cycle 0, so the next cycle already reads 1
               cyc <= LAT_W'(1);
               stage_cnt <= '0;
               count_err <= '0;
               err_flags <= '0;
            end
            FEED, DRAIN: begin
               pix_cnt <= pix_nxt;
               cyc <= cyc_nxt;
               stage_cnt <= cnt_nxt;
               if (state == DRAIN && pix_valid) err_flags[1] <= 1'b1;
               if (result_valid) begin
                  state <= IDLE;
                  decision_q <= result_data;
                  latency <= cyc;
                  count_err <= err_nxt;
                  done <= 1'b1;
                  if (state == FEED && !last_pix) err_flags[0] <= 1'b1;
               end else if (cyc >= TO_LAST) begin
                  state <= HALT;
                  err_flags[2] <= 1'b1;
                  done <= 1'b1;
               end else if (last_pix) begin
                  state <= DRAIN;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
